// File: rtl/hs_fifo_ctl.sv
// Synchronous valid/ready FIFO with arbitrary depth, occupancy count, watermark flags and flush.
// Define HS_FIFO_CTL_PEAK_EN to add the peak_count high-water-mark output.
module hs_fifo_ctl #(
    parameter int DATA_WD  = 8,
    parameter int DEPTH    = 12,
    parameter int AF_LEVEL = 10,
    parameter int AE_LEVEL = 2,
    localparam int CNT_WD  = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [DATA_WD-1:0] in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic [DATA_WD-1:0] out_data,
    input  logic               out_ready,
    output logic [CNT_WD-1:0]  count,
`ifdef HS_FIFO_CTL_PEAK_EN
    output logic [CNT_WD-1:0]  peak_count,
`endif
    output logic               almost_full,
    output logic               almost_empty
);

    localparam int PTR_WD = $clog2(DEPTH);
    localparam logic [PTR_WD-1:0] PTR_ZERO = PTR_WD'(0);
    localparam logic [PTR_WD-1:0] PTR_ONE  = PTR_WD'(1);
    localparam logic [PTR_WD-1:0] PTR_LAST = PTR_WD'(DEPTH - 1);
    localparam logic [CNT_WD-1:0] CNT_ZERO = CNT_WD'(0);
    localparam logic [CNT_WD-1:0] CNT_ONE  = CNT_WD'(1);
    localparam logic [CNT_WD-1:0] CNT_FULL = CNT_WD'(DEPTH);
    localparam logic [CNT_WD-1:0] CNT_AF   = CNT_WD'(AF_LEVEL);
    localparam logic [CNT_WD-1:0] CNT_AE   = CNT_WD'(AE_LEVEL);

    // Illegal configurations stop elaboration.
    if (DATA_WD < 1) begin : g_err_data_wd
        $error("hs_fifo_ctl: DATA_WD must be >= 1");
    end
    if (DEPTH < 2) begin : g_err_depth
        $error("hs_fifo_ctl: DEPTH must be >= 2");
    end
    if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_err_af
        $error("hs_fifo_ctl: AF_LEVEL must be in 1..DEPTH");
    end
    if ((AE_LEVEL < 0) || (AE_LEVEL > DEPTH - 1)) begin : g_err_ae
        $error("hs_fifo_ctl: AE_LEVEL must be in 0..DEPTH-1");
    end

    logic [DATA_WD-1:0] mem_r [DEPTH];
    logic [PTR_WD-1:0]  wptr_r, rptr_r, wptr_nxt_s, rptr_nxt_s;
    logic [CNT_WD-1:0]  count_r, count_nxt_s;
    logic               push_s, pop_s;

    // Pointers wrap by compare so non-power-of-two depths never index past the last entry.
    function automatic logic [PTR_WD-1:0] ptr_adv(input logic [PTR_WD-1:0] p);
        return (p == PTR_LAST) ? PTR_ZERO : p + PTR_ONE;
    endfunction

    assign in_ready     = (count_r != CNT_FULL) && !flush;
    assign out_valid    = (count_r != CNT_ZERO) && !flush;
    assign push_s       = in_valid && in_ready;
    assign pop_s        = out_valid && out_ready;
    assign out_data     = mem_r[rptr_r];
    assign count        = count_r;
    assign almost_full  = (count_r >= CNT_AF);
    assign almost_empty = (count_r <= CNT_AE);

    // Next-state for pointers and occupancy; flush overrides any handshake.
    always_comb begin
        wptr_nxt_s  = wptr_r;
        rptr_nxt_s  = rptr_r;
        count_nxt_s = count_r;
        if (flush) begin
            wptr_nxt_s  = PTR_ZERO;
            rptr_nxt_s  = PTR_ZERO;
            count_nxt_s = CNT_ZERO;
        end else begin
            if (push_s) begin
                wptr_nxt_s = ptr_adv(wptr_r);
            end else begin
                wptr_nxt_s = wptr_r;
            end
            if (pop_s) begin
                rptr_nxt_s = ptr_adv(rptr_r);
            end else begin
                rptr_nxt_s = rptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_nxt_s = count_r + CNT_ONE;
                2'b01:   count_nxt_s = count_r - CNT_ONE;
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_r  <= PTR_ZERO;
            rptr_r  <= PTR_ZERO;
            count_r <= CNT_ZERO;
        end else begin
            wptr_r  <= wptr_nxt_s;
            rptr_r  <= rptr_nxt_s;
            count_r <= count_nxt_s;
        end
    end

    // Storage write; contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wptr_r] <= in_data;
        end
    end

`ifdef HS_FIFO_CTL_PEAK_EN
    logic [CNT_WD-1:0] peak_r;

    // High-water mark of occupancy, cleared by flush.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            peak_r <= CNT_ZERO;
        end else if (flush) begin
            peak_r <= CNT_ZERO;
        end else if (count_nxt_s > peak_r) begin
            peak_r <= count_nxt_s;
        end else begin
            peak_r <= peak_r;
        end
    end

    assign peak_count = peak_r;
`endif

endmodule

// File: tb/tb_hs_fifo_ctl.sv
// Self-checking bench for hs_fifo_ctl: directed vector table, hand-written corner
// sequences, and randomized traffic checked against a queue-based model.
module tb_hs_fifo_ctl;

    localparam int DEPTH  = 12;
    localparam int CNT_WD = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rstn;
    logic              flush, in_valid, out_ready;
    logic [7:0]        in_data;
    logic              in_ready, out_valid, almost_full, almost_empty;
    logic [7:0]        out_data;
    logic [CNT_WD-1:0] count;
`ifdef HS_FIFO_CTL_PEAK_EN
    logic [CNT_WD-1:0] peak_count;
`endif

    hs_fifo_ctl #(.DATA_WD(8), .DEPTH(DEPTH), .AF_LEVEL(10), .AE_LEVEL(2)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .count(count),
`ifdef HS_FIFO_CTL_PEAK_EN
        .peak_count(peak_count),
`endif
        .almost_full(almost_full), .almost_empty(almost_empty)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the FIFO contents as a queue plus the running peak.
    logic [7:0] q[$];
    int         peak_m = 0;

    typedef struct {
        logic       fl, iv;
        logic [7:0] id;
        logic       ordy;
        logic       e_ir, e_ov;
        logic [7:0] e_od;
        int         e_cnt;
        logic       e_af, e_ae;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic fl, iv, input logic [7:0] id, input logic ordy,
                                input logic ir, ov, input logic [7:0] od, input int cnt);
        vec_t v;
        v.fl = fl; v.iv = iv; v.id = id; v.ordy = ordy;
        v.e_ir = ir; v.e_ov = ov; v.e_od = od; v.e_cnt = cnt;
        v.e_af = (cnt >= 10); v.e_ae = (cnt <= 2);
        return v;
    endfunction

    task automatic check_model();
        int sz = q.size();
        chk("in_ready", int'(in_ready), int'(sz < DEPTH && !flush));
        chk("out_valid", int'(out_valid), int'(sz > 0 && !flush));
        if (sz > 0 && !flush) chk("out_data", int'(out_data), int'(q[0]));
        chk("count", int'(count), sz);
        chk("almost_full", int'(almost_full), int'(sz >= 10));
        chk("almost_empty", int'(almost_empty), int'(sz <= 2));
`ifdef HS_FIFO_CTL_PEAK_EN
        chk("peak_count", int'(peak_count), peak_m);
`endif
    endtask

    task automatic model_update(input logic fl, iv, input logic [7:0] id, input logic ordy);
        bit acc_in  = (q.size() < DEPTH) && !fl && iv;
        bit acc_out = (q.size() > 0) && !fl && ordy;
        if (fl) begin
            q.delete();
            peak_m = 0;
        end else begin
            if (acc_out) void'(q.pop_front());
            if (acc_in) q.push_back(id);
            if (q.size() > peak_m) peak_m = q.size();
        end
    endtask

    // One clock: drive at posedge+1, compare at negedge, advance model at posedge.
    task automatic cyc(input logic fl, iv, input logic [7:0] id, input logic ordy);
        flush = fl; in_valid = iv; in_data = id; out_ready = ordy;
        @(negedge clk);
        check_model();
        @(posedge clk);
        model_update(fl, iv, id, ordy);
        #1;
    endtask

    task automatic apply_vec(input vec_t v);
        flush = v.fl; in_valid = v.iv; in_data = v.id; out_ready = v.ordy;
        @(negedge clk);
        chk("vec in_ready", int'(in_ready), int'(v.e_ir));
        chk("vec out_valid", int'(out_valid), int'(v.e_ov));
        if (v.e_ov) chk("vec out_data", int'(out_data), int'(v.e_od));
        chk("vec count", int'(count), v.e_cnt);
        chk("vec almost_full", int'(almost_full), int'(v.e_af));
        chk("vec almost_empty", int'(almost_empty), int'(v.e_ae));
        @(posedge clk);
        model_update(v.fl, v.iv, v.id, v.ordy);
        #1;
    endtask

    initial begin
        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;

        // Empty pass-through, then simultaneous pop/push at count 1.
        vecs.push_back(mk(1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h00, 0));
        vecs.push_back(mk(1'b0, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b1, 8'hA5, 1));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h5A, 1));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h5A, 1));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 0));
        // Fill with 0x01..0x0C, consumer stalled.
        for (int k = 1; k <= DEPTH; k++)
            vecs.push_back(mk(1'b0, 1'b1, 8'(k), 1'b0, 1'b1, k > 1, 8'h01, k - 1));
        // Full: push rejected; pop-on-full rejects push; push lands next cycle.
        vecs.push_back(mk(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h01, 12));
        vecs.push_back(mk(1'b0, 1'b1, 8'hD0, 1'b1, 1'b0, 1'b1, 8'h01, 12));
        vecs.push_back(mk(1'b0, 1'b1, 8'hD0, 1'b0, 1'b1, 1'b1, 8'h02, 11));
        // Drain: 0x02..0x0C then 0xD0.
        for (int k = 1; k <= DEPTH; k++)
            vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, (13 - k) != DEPTH, 1'b1,
                              (k <= 11) ? 8'(k + 1) : 8'hD0, 13 - k));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 0));

        // Outputs held in reset.
        #3;
        chk("rst in_ready", int'(in_ready), 1);
        chk("rst out_valid", int'(out_valid), 0);
        chk("rst count", int'(count), 0);
        chk("rst almost_full", int'(almost_full), 0);
        chk("rst almost_empty", int'(almost_empty), 1);
        @(posedge clk); #1;
        rstn = 1'b1;

        foreach (vecs[i]) apply_vec(vecs[i]);

        // Flush at count 7 with both handshakes requested, held two cycles.
        for (int k = 0; k < 7; k++) cyc(1'b0, 1'b1, 8'(8'h40 + k), 1'b0);
        cyc(1'b1, 1'b1, 8'hEE, 1'b1);
        cyc(1'b1, 1'b1, 8'hEF, 1'b1);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        chk("post-flush count", int'(count), 0);

        // Randomized traffic with push-heavy and pop-heavy phases; rare flushes.
        for (int i = 0; i < 600; i++) begin
            int ph = (i / 50) % 2;
            logic iv_r = (ph == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            logic or_r = (ph == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            logic fl_r = ($urandom_range(0, 99) == 0);
            cyc(fl_r, iv_r, 8'($urandom), or_r);
        end
        cyc(1'b1, 1'b0, 8'h00, 1'b0);

        // Async reset mid-stream at count 5 while a handshake is in progress.
        for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, 8'(8'h60 + k), 1'b0);
        in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b1;
        #1 rstn = 1'b0;
        #1;
        chk("async count", int'(count), 0);
        chk("async out_valid", int'(out_valid), 0);
        chk("async in_ready", int'(in_ready), 1);
`ifdef HS_FIFO_CTL_PEAK_EN
        chk("async peak", int'(peak_count), 0);
`endif
        q.delete();
        peak_m = 0;
        in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        cyc(1'b0, 1'b1, 8'h3C, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        chk("post-reset head", int'(out_data), 8'h3C);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
